// File: rtl/tr_pkg.sv
// Shared definitions for the step pulse generator: FSM state encoding and
// default widths for the period and pulse counters.
package tr_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/step_phase_cnt.sv
// Phase counter for one step period plus the registered step level.
// Periods below 2 are stretched to 2 so every pulse has a high and a low cycle.
module step_phase_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] period,
    output logic             at_end,
    output logic             step_out
);

    logic [WIDTH-1:0] phase;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] period_eff;
    logic [WIDTH-1:0] phase_nxt;

    assign period_eff = (period < WIDTH'(2)) ? WIDTH'(2) : period;
    assign phase_nxt  = phase + WIDTH'(1);
    assign at_end     = (phase == period_q - WIDTH'(1));

    // A freshly loaded period always starts high: phase 0 < period_eff/2 since period_eff >= 2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase    <= '0;
            period_q <= WIDTH'(2);
            step_out <= 1'b0;
        end else if (clear) begin
            phase    <= '0;
            step_out <= 1'b0;
        end else if (load) begin
            phase    <= '0;
            period_q <= period_eff;
            step_out <= 1'b1;
        end else if (advance) begin
            phase    <= phase_nxt;
            step_out <= (phase_nxt < (period_q >> 1));
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for a stepper driver: free-running or counted
// pulse trains, with period and direction updates applied only on period boundaries.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | driver disabled, waiting for a valid run request
// ST_RUN  | emitting step pulses, busy high
// ST_DONE | counted run finished, driver stays enabled until drv_en drops
module step_pulse_gen
    import tr_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 drv_en,
    input  logic                 dir,
    input  logic                 counter_en,
    input  logic [WIDTH-1:0]     period,
    input  logic [CNT_WIDTH-1:0] target,
    output logic                 step_out,
    output logic                 dir_out,
    output logic                 ena_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pulse_cnt
);

    state_t               state_q;
    state_t               state_d;
    logic                 cnt_mode_q;
    logic [CNT_WIDTH-1:0] target_q;
    logic [CNT_WIDTH-1:0] pulse_cnt_inc;
    logic                 start_ok;
    logic                 start;
    logic                 cnt_inc;
    logic                 relatch_dir;
    logic                 pc_clear;
    logic                 pc_load;
    logic                 pc_advance;
    logic                 at_end;

    assign pulse_cnt_inc = pulse_cnt + CNT_WIDTH'(1);
    assign start_ok      = drv_en && (period != '0) && (!counter_en || (target != '0));

    step_phase_cnt #(.WIDTH(WIDTH)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .clear    (pc_clear),
        .load     (pc_load),
        .advance  (pc_advance),
        .period   (period),
        .at_end   (at_end),
        .step_out (step_out)
    );

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        cnt_inc     = 1'b0;
        relatch_dir = 1'b0;
        pc_clear    = 1'b0;
        pc_load     = 1'b0;
        pc_advance  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                    pc_load = 1'b1;
                end else begin
                    pc_clear = 1'b1;
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident boundary, so the count is not bumped.
                if (!drv_en) begin
                    state_d  = ST_IDLE;
                    pc_clear = 1'b1;
                end else if (at_end) begin
                    cnt_inc = 1'b1;
                    if (cnt_mode_q && (pulse_cnt_inc == target_q)) begin
                        state_d  = ST_DONE;
                        pc_clear = 1'b1;
                    end else if (period == '0) begin
                        state_d  = ST_IDLE;
                        pc_clear = 1'b1;
                    end else begin
                        pc_load     = 1'b1;
                        relatch_dir = 1'b1;
                    end
                end else begin
                    pc_advance = 1'b1;
                end
            end
            ST_DONE: begin
                pc_clear = 1'b1;
                if (!drv_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pc_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            dir_out    <= 1'b0;
            ena_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pulse_cnt  <= '0;
            cnt_mode_q <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q <= state_d;
            ena_out <= (state_d != ST_IDLE);
            busy    <= (state_d == ST_RUN);
            done    <= (state_d == ST_DONE);
            if (start) begin
                dir_out    <= dir;
                cnt_mode_q <= counter_en;
                target_q   <= target;
                pulse_cnt  <= '0;
            end else begin
                if (relatch_dir) begin
                    dir_out <= dir;
                end
                if (cnt_inc) begin
                    pulse_cnt <= pulse_cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: expected outputs are queued per cycle
// and compared one cycle later, just after the active edge.
module tb_step_pulse_gen;

    typedef struct packed {
        logic        step;
        logic        dir;
        logic        ena;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        drv_en;
    logic        dir;
    logic        counter_en;
    logic [15:0] period;
    logic [15:0] target;
    logic        step_out;
    logic        dir_out;
    logic        ena_out;
    logic        busy;
    logic        done;
    logic [15:0] pulse_cnt;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    step_pulse_gen dut (
        .clk        (clk),
        .rst        (rst),
        .drv_en     (drv_en),
        .dir        (dir),
        .counter_en (counter_en),
        .period     (period),
        .target     (target),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .ena_out    (ena_out),
        .busy       (busy),
        .done       (done),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk_run(input logic s, input logic d, input int c);
        return '{step: s, dir: d, ena: 1'b1, busy: 1'b1, done: 1'b0, cnt: 16'(c)};
    endfunction

    function automatic obs_t mk_idle(input logic d, input int c);
        return '{step: 1'b0, dir: d, ena: 1'b0, busy: 1'b0, done: 1'b0, cnt: 16'(c)};
    endfunction

    function automatic obs_t mk_done(input logic d, input int c);
        return '{step: 1'b0, dir: d, ena: 1'b1, busy: 1'b0, done: 1'b1, cnt: 16'(c)};
    endfunction

    task automatic cyc(input string tag, input obs_t e);
        obs_t  obs;
        obs_t  exp_v;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        obs   = '{step: step_out, dir: dir_out, ena: ena_out, busy: busy, done: done, cnt: pulse_cnt};
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", t, obs, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; drv_en = 1'b0; dir = 1'b0; counter_en = 1'b0;
        period = 16'd0; target = 16'd0;
        cyc("reset", mk_idle(1'b0, 0));
        rst = 1'b1;
        cyc("idle_after_reset", mk_idle(1'b0, 0));

        // counted run: period 10, 3 pulses; target change mid-run is ignored
        period = 16'd10; counter_en = 1'b1; target = 16'd3; drv_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) target = 16'd1;
            cyc("counted_run", mk_run((i % 10) < 5, 1'b0, i / 10));
        end
        cyc("counted_done", mk_done(1'b0, 3));
        cyc("done_hold", mk_done(1'b0, 3));
        drv_en = 1'b0;
        cyc("done_exit", mk_idle(1'b0, 3));

        // period 1 stretched to 2, free-run
        period = 16'd1; counter_en = 1'b0; dir = 1'b1; drv_en = 1'b1;
        for (int i = 0; i < 8; i++) cyc("period1", mk_run((i % 2) == 0, 1'b1, i / 2));
        drv_en = 1'b0;
        cyc("period1_abort", mk_idle(1'b1, 3));

        // period 8 -> 4 and dir 0 -> 1 mid-pulse
        period = 16'd8; dir = 1'b0; drv_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 2) begin period = 16'd4; dir = 1'b1; end
            if (i < 8) cyc("retune_old", mk_run(i < 4, 1'b0, 0));
            else       cyc("retune_new", mk_run(((i - 8) % 4) < 2, 1'b1, 1 + (i - 8) / 4));
        end
        drv_en = 1'b0;
        cyc("retune_stop", mk_idle(1'b1, 2));

        // abort at phase 2 of the second period of 10
        period = 16'd10; dir = 1'b0; drv_en = 1'b1;
        for (int i = 0; i < 13; i++) cyc("abort_run", mk_run((i % 10) < 5, 1'b0, i / 10));
        drv_en = 1'b0;
        cyc("abort_phase2", mk_idle(1'b0, 1));
        cyc("abort_idle", mk_idle(1'b0, 1));

        // reset while step_out is high, then restart immediately
        period = 16'd6; dir = 1'b1; drv_en = 1'b1;
        cyc("pre_reset0", mk_run(1'b1, 1'b1, 0));
        cyc("pre_reset1", mk_run(1'b1, 1'b1, 0));
        rst = 1'b0;
        cyc("reset_in_run", mk_idle(1'b0, 0));
        rst = 1'b1;
        for (int i = 0; i < 7; i++) cyc("restart", mk_run((i % 6) < 3, 1'b1, i / 6));
        drv_en = 1'b0;
        cyc("restart_stop", mk_idle(1'b1, 1));

        // invalid starts stay idle
        counter_en = 1'b1; target = 16'd0; period = 16'd10; dir = 1'b0; drv_en = 1'b1;
        for (int i = 0; i < 3; i++) cyc("target0", mk_idle(1'b1, 1));
        counter_en = 1'b0; period = 16'd0;
        for (int i = 0; i < 3; i++) cyc("period0", mk_idle(1'b1, 1));

        // odd period 5 (2 high / 3 low); period forced to 0 takes effect at boundary
        period = 16'd5;
        cyc("odd_start", mk_run(1'b1, 1'b0, 0));
        period = 16'd0;
        for (int i = 1; i < 5; i++) cyc("odd_run", mk_run(i < 2, 1'b0, 0));
        cyc("period0_boundary", mk_idle(1'b0, 1));
        cyc("period0_idle", mk_idle(1'b0, 1));
        drv_en = 1'b0;
        cyc("final_idle", mk_idle(1'b0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
